// File: rtl/vga_sync_if.sv
// VGA timing bundle produced by vga_sync_gen and consumed by the pixel renderer.
interface vga_sync_if #(
  parameter int CNT_W = 10
);
  logic             pix_tick;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             frame_start;

  modport master (
    output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );

  modport slave (
    input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing on clk_in, stepped by rising edges of the sampled pix_clk.
// Define SYNC_ACTIVE_HIGH_EN for active-high hsync/vsync (default active-low).
//
// state      | meaning
// ST_VISIBLE | h_cnt in visible area
// ST_FRONT   | horizontal front porch
// ST_SYNC    | hsync pulse
// ST_BACK    | back porch; last tick ends the line
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CNT_W     = 10
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_clk,
  vga_sync_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_LAST   = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] H_FP_LAST    = CNT_W'(H_VISIBLE + H_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS_N      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

`ifdef SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_VISIBLE = 2'd0,
    ST_FRONT   = 2'd1,
    ST_SYNC    = 2'd2,
    ST_BACK    = 2'd3
  } h_state_t;

  h_state_t         h_state, h_state_nxt;
  logic [CNT_W-1:0] h_cnt, h_cnt_nxt;
  logic [CNT_W-1:0] v_cnt, v_cnt_nxt;
  logic             s1, s2, s3;
  logic             tick;
  logic             line_end;
  logic             in_hsync, in_vsync, in_video;

  // pix_clk is asynchronous data: s1/s2 synchronise, s3 holds the previous level
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pix_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_state <= ST_VISIBLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      h_state <= h_state_nxt;
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
    end
  end

  always_comb begin
    h_state_nxt = h_state;
    h_cnt_nxt   = h_cnt;
    v_cnt_nxt   = v_cnt;
    line_end    = 1'b0;
    if (tick) begin
      h_cnt_nxt = h_cnt + 1'b1;
      case (h_state)
        ST_VISIBLE: if (h_cnt == H_VIS_LAST)  h_state_nxt = ST_FRONT;
        ST_FRONT:   if (h_cnt == H_FP_LAST)   h_state_nxt = ST_SYNC;
        ST_SYNC:    if (h_cnt == H_SYNC_LAST) h_state_nxt = ST_BACK;
        ST_BACK: begin
          if (h_cnt == H_LAST) begin
            h_cnt_nxt   = '0;
            h_state_nxt = ST_VISIBLE;
            line_end    = 1'b1;
          end
        end
        default: h_state_nxt = ST_VISIBLE;
      endcase
      if (line_end) begin
        v_cnt_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
    end
  end

  assign in_hsync = (h_state == ST_SYNC);
  assign in_vsync = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
  assign in_video = (h_state == ST_VISIBLE) && (v_cnt < V_VIS_N);

  // Outputs describe the pixel being left this tick, so they lag the counters by one
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      vga.pix_tick    <= 1'b0;
      vga.hsync       <= ~SYNC_ON;
      vga.vsync       <= ~SYNC_ON;
      vga.video_on    <= 1'b0;
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.pix_tick    <= tick;
      vga.frame_start <= 1'b0;
      if (tick) begin
        vga.pixel_x     <= h_cnt;
        vga.pixel_y     <= v_cnt;
        vga.video_on    <= in_video;
        vga.hsync       <= in_hsync ? SYNC_ON : ~SYNC_ON;
        vga.vsync       <= in_vsync ? SYNC_ON : ~SYNC_ON;
        vga.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen; a shortened vertical frame keeps full-frame runs brief.
module tb_vga_sync_gen;

  localparam int HT    = 800;
  localparam int VV    = 8;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

`ifdef SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_IDLE = 1'b0;
`else
  localparam logic SYNC_IDLE = 1'b1;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  localparam exp_t RST_EXP = '{x: 10'd0, y: 10'd0, vid: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE, fs: 1'b0};

  logic clk_in  = 1'b0;
  logic reset   = 1'b0;
  logic pix_clk = 1'b0;
  logic mon_en  = 1'b0;

  int   total = 0;
  int   bad   = 0;
  int   n     = 0;
  exp_t sb[$];
  exp_t last = RST_EXP;
  exp_t obs;
  exp_t exp_v;

  vga_sync_if #(.CNT_W(10)) vga ();

  vga_sync_gen #(
    .V_VISIBLE(VV),
    .V_FP(VF),
    .V_SYNC(VS),
    .V_BP(VB)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .pix_clk(pix_clk),
    .vga    (vga)
  );

  always #5 clk_in = ~clk_in;

  function automatic exp_t model(input int idx);
    exp_t e;
    int   x;
    int   y;
    x     = idx % HT;
    y     = (idx / HT) % VT;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vid = (x < 640) && (y < VV);
    e.hs  = SYNC_IDLE ^ ((x >= 656) && (x < 752));
    e.vs  = SYNC_IDLE ^ ((y >= VV + VF) && (y < VV + VF + VS));
    e.fs  = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic pix_pulse(input int hi, input int lo, input bit push);
    @(negedge clk_in);
    pix_clk = 1'b1;
    if (push) begin
      sb.push_back(model(n));
      n++;
    end
    repeat (hi) @(negedge clk_in);
    pix_clk = 1'b0;
    repeat (lo - 1) @(negedge clk_in);
  endtask

  // Monitor: reset values while in reset, scoreboard pop on each tick, hold otherwise
  always @(negedge clk_in) begin
    if (mon_en) begin
      obs = {vga.pixel_x, vga.pixel_y, vga.video_on, vga.hsync, vga.vsync, vga.frame_start};
      if (!reset) begin
        last = RST_EXP;
        total++;
        assert (vga.pix_tick === 1'b0 && obs === RST_EXP)
          else begin bad++; $error("FAIL in_reset: observed=%h tick=%b expected=%h", obs, vga.pix_tick, RST_EXP); end
      end else if (vga.pix_tick === 1'b1) begin
        total++;
        assert (sb.size() != 0)
          else begin bad++; $error("FAIL unexpected_tick: observed=%h expected=no tick", obs); end
        if (sb.size() != 0) begin
          exp_v = sb.pop_front();
          total++;
          assert (obs === exp_v)
            else begin bad++; $error("FAIL tick_pixel: observed=%h expected=%h", obs, exp_v); end
          last    = exp_v;
          last.fs = 1'b0;
        end
      end else begin
        total++;
        assert (obs === last && vga.pix_tick === 1'b0)
          else begin bad++; $error("FAIL hold: observed=%h tick=%b expected=%h", obs, vga.pix_tick, last); end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_in);
    mon_en = 1'b1;

    // reset held with pix_clk toggling
    repeat (5) pix_pulse(1, 1, 1'b0);
    repeat (3) @(negedge clk_in);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk_in);

    // pix_clk toggling every 2 cycles: one-cycle tick, 3 cycles after each rise
    for (int p = 0; p < 3; p++) begin
      pix_clk = 1'b1;
      sb.push_back(model(n));
      n++;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk_in);
        if (k == 2) pix_clk = 1'b0;
        total++;
        assert (vga.pix_tick === logic'(k == 3))
          else begin bad++; $error("FAIL tick_timing: observed=%b expected=%b at p=%0d k=%0d", vga.pix_tick, logic'(k == 3), p, k); end
      end
    end

    // run to pixel 300, stall with pix_clk high for 50 cycles, then resume
    while (n < 300) pix_pulse(1, 1, 1'b1);
    pix_pulse(50, 1, 1'b1);

    // full frame, wrap, and into the next frame up to pixel (700,5)
    while (n <= FRAME + 5 * HT + 700) pix_pulse(1, 1, 1'b1);
    repeat (4) @(negedge clk_in);
    total++;
    assert (sb.size() == 0)
      else begin bad++; $error("FAIL drain_before_reset: observed=%0d expected=0", sb.size()); end

    // asynchronous reset mid-frame
    #2 reset = 1'b0;
    #1;
    obs = {vga.pixel_x, vga.pixel_y, vga.video_on, vga.hsync, vga.vsync, vga.frame_start};
    total++;
    assert (obs === RST_EXP && vga.pix_tick === 1'b0)
      else begin bad++; $error("FAIL async_reset: observed=%h expected=%h", obs, RST_EXP); end
    sb.delete();
    n = 0;
    repeat (4) @(negedge clk_in);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_in);
    repeat (10) pix_pulse(1, 1, 1'b1);
    repeat (6) @(negedge clk_in);
    total++;
    assert (sb.size() == 0)
      else begin bad++; $error("FAIL drain_end: observed=%0d expected=0", sb.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
